cla_adder_pipe: RTL

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor, the successor to the 4-bit lookahead carry unit.
- Datapath is built from 4-bit groups whose group propagate/generate feed a second lookahead level.
- Adds a subtract mode, status flags and a valid/ready elastic pipeline with backpressure.
- Sits between operand-issue logic and result writeback in the ALU datapath.

---
 rtl/cla_adder_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor. 4-bit lookahead groups feed a
// second, fully flattened lookahead level; elastic valid/ready pipeline buffers 2 beats.
module cla_adder_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NG = WIDTH / 4;

   // Group generate of one 4-bit lookahead block.
   function automatic logic grp_generate(input logic [3:0] p, input logic [3:0] g);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   function automatic logic [3:0] grp_carries(input logic [3:0] p, input logic [3:0] g,
                                              input logic c_in);
      logic [3:0] c;
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
      return c;
   endfunction

   // Each group carry is a flat sum-of-products over all lower groups, not a ripple.
   function automatic logic [NG:0] lookahead_carries(input logic [NG-1:0] gp,
                                                     input logic [NG-1:0] gg,
                                                     input logic c0);
      logic [NG:0] c;
      logic        acc;
      logic        prod;
      c    = '0;
      c[0] = c0;
      for (int k = 0; k < NG; k++) begin
         acc  = gg[k];
         prod = gp[k];
         for (int j = k - 1; j >= 0; j--) begin
            acc  = acc | (prod & gg[j]);
            prod = prod & gp[j];
         end
         c[k+1] = acc | (prod & c0);
      end
      return c;
   endfunction

   logic [WIDTH-1:0] b_e_s;
   logic             c0_s;
   logic [WIDTH-1:0] p_s;
   logic [WIDTH-1:0] g_s;
   logic [NG-1:0]    gp_s;
   logic [NG-1:0]    gg_s;

   logic             s2_adv_s;
   logic             s1_adv_s;
   logic             s1_load_s;
   logic             s2_load_s;

   logic             s1_valid_r;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] g_r;
   logic [NG-1:0]    gp_r;
   logic [NG-1:0]    gg_r;
   logic             c0_r;
   logic             a_msb_r;
   logic             b_msb_r;

   logic [NG:0]      cg_s;
   logic [WIDTH-1:0] c_s;
   logic [WIDTH-1:0] sum_s;
   logic             ovf_s;

   logic             s2_valid_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             zero_r;

   // Handshake: in_ready depends on pipeline state and out_ready only, never on in_valid.
   always_comb begin
      s2_adv_s  = ~s2_valid_r | out_ready;
      s1_adv_s  = ~s1_valid_r | s2_adv_s;
      s1_load_s = in_valid & s1_adv_s;
      s2_load_s = s1_valid_r & s2_adv_s;
      in_ready  = s1_adv_s;
   end

   // Stage 1 combinational: effective operands, bit and group propagate/generate.
   always_comb begin
      if (sub) begin
         b_e_s = ~b;
         c0_s  = 1'b1;
      end else begin
         b_e_s = b;
         c0_s  = cin;
      end
      p_s  = a ^ b_e_s;
      g_s  = a & b_e_s;
      gp_s = '0;
      gg_s = '0;
      for (int k = 0; k < NG; k++) begin
         gp_s[k] = &p_s[4*k +: 4];
         gg_s[k] = grp_generate(p_s[4*k +: 4], g_s[4*k +: 4]);
      end
   end

   // Stage 1 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         p_r        <= '0;
         g_r        <= '0;
         gp_r       <= '0;
         gg_r       <= '0;
         c0_r       <= 1'b0;
         a_msb_r    <= 1'b0;
         b_msb_r    <= 1'b0;
      end else begin
         if (s1_adv_s) begin
            s1_valid_r <= in_valid;
         end
         if (s1_load_s) begin
            p_r     <= p_s;
            g_r     <= g_s;
            gp_r    <= gp_s;
            gg_r    <= gg_s;
            c0_r    <= c0_s;
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b_e_s[WIDTH-1];
         end
      end
   end

   // Stage 2 combinational: second-level group carries, in-group carries, sum and flags.
   always_comb begin
      cg_s = lookahead_carries(gp_r, gg_r, c0_r);
      c_s  = '0;
      for (int k = 0; k < NG; k++) begin
         c_s[4*k +: 4] = grp_carries(p_r[4*k +: 4], g_r[4*k +: 4], cg_s[k]);
      end
      sum_s = p_r ^ c_s;
      // Like-signed operands producing an opposite-signed result.
      ovf_s = ~(a_msb_r ^ b_msb_r) & (a_msb_r ^ sum_s[WIDTH-1]);
   end

   // Stage 2 register; holds the presented result until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         sum_r      <= '0;
         cout_r     <= 1'b0;
         ovf_r      <= 1'b0;
         zero_r     <= 1'b0;
      end else begin
         if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
         end
         if (s2_load_s) begin
            sum_r  <= sum_s;
            cout_r <= cg_s[NG];
            ovf_r  <= ovf_s;
            zero_r <= ~|sum_s;
         end
      end
   end

   assign out_valid = s2_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;

endmodule
